// File: rtl/lut_bank_pipe_if.sv
// Signal bundle for lut_bank_pipe: truth-table write port, input stream and
// output stream. The design side uses the slave modport.
interface lut_bank_pipe_if #(
    parameter int K        = 4,
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16
);
    localparam int TW   = 1 << K;
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                  cfg_we;
    logic [CH_W-1:0]       cfg_ch;
    logic [TW-1:0]         cfg_tt;
    logic                  cfg_err;

    logic                  in_valid;
    logic                  in_ready;
    logic [CHANNELS*K-1:0] in_data;

    logic                  out_valid;
    logic                  out_ready;
    logic [CHANNELS-1:0]   out_data;

    logic [CNT_W-1:0]      eval_count;

    modport master (
        output cfg_we, cfg_ch, cfg_tt, in_valid, in_data, out_ready,
        input  cfg_err, in_ready, out_valid, out_data, eval_count
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_tt, in_valid, in_data, out_ready,
        output cfg_err, in_ready, out_valid, out_data, eval_count
    );
endinterface

// File: rtl/lut_bank_pipe.sv
// Bank of CHANNELS runtime-loadable K-input truth tables evaluated in a
// two-stage valid/ready pipeline, with a saturating delivered-beat counter.
module lut_bank_pipe #(
    parameter int                K        = 4,
    parameter int                CHANNELS = 4,
    parameter logic [(1<<K)-1:0] INIT_TT  = 16'h1796,
    parameter int                CNT_W    = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    lut_bank_pipe_if.slave bus
);
    localparam int TW   = 1 << K;
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS-1:0][TW-1:0] tt_q, tt_d;
    logic                        cfg_err_q, cfg_err_d;
    logic                        s1_valid_q, s1_valid_d;
    logic [CHANNELS-1:0]         s1_data_q, s1_data_d;
    logic                        s2_valid_q, s2_valid_d;
    logic [CHANNELS-1:0]         s2_data_q, s2_data_d;
    logic [CNT_W-1:0]            eval_count_q, eval_count_d;

    logic                        s1_en;
    logic                        s2_en;
    logic                        accept;
    logic                        deliver;
    logic                        cfg_hit;
    logic [CHANNELS-1:0]         lut_bits;

    // S2 frees when empty or draining; S1 may advance whenever S2 can take it.
    assign s2_en   = !s2_valid_q || bus.out_ready;
    assign s1_en   = !s1_valid_q || s2_en;
    assign accept  = bus.in_valid && s1_en;
    assign deliver = s2_valid_q && bus.out_ready;

    always_comb begin
        // NOTE: every variable gets a default before any branch so that no
        // path leaves it unassigned, which would otherwise infer a latch.
        tt_d         = tt_q;
        cfg_err_d    = 1'b0;
        cfg_hit      = 1'b0;
        s1_valid_d   = s1_valid_q;
        s1_data_d    = s1_data_q;
        s2_valid_d   = s2_valid_q;
        s2_data_d    = s2_data_q;
        eval_count_d = eval_count_q;
        lut_bits     = '0;

        // Lookup reads the current tables, so a same-cycle write is not seen.
        for (int c = 0; c < CHANNELS; c++) begin
            lut_bits[c] = tt_q[c][bus.in_data[c*K +: K]];
        end

        if (bus.cfg_we) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (bus.cfg_ch == CH_W'(c)) begin
                    tt_d[c] = bus.cfg_tt;
                    cfg_hit = 1'b1;
                end
            end
            cfg_err_d = !cfg_hit;
        end

        if (s1_en) begin
            s1_valid_d = bus.in_valid;
            if (accept) begin
                s1_data_d = lut_bits;
            end
        end

        if (s2_en) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = s1_data_q;
            end
        end

        if (deliver && (eval_count_q != {CNT_W{1'b1}})) begin
            eval_count_d = eval_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge value of every other flop.
        if (!rst_n) begin
            // NOTE: the table array is reset because INIT_TT is part of the
            // block's behaviour; a plain storage array would not need it.
            tt_q         <= {CHANNELS{INIT_TT}};
            cfg_err_q    <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_data_q    <= '0;
            s2_valid_q   <= 1'b0;
            s2_data_q    <= '0;
            eval_count_q <= '0;
        end else begin
            tt_q         <= tt_d;
            cfg_err_q    <= cfg_err_d;
            s1_valid_q   <= s1_valid_d;
            s1_data_q    <= s1_data_d;
            s2_valid_q   <= s2_valid_d;
            s2_data_q    <= s2_data_d;
            eval_count_q <= eval_count_d;
        end
    end

    assign bus.in_ready   = s1_en;
    assign bus.out_valid  = s2_valid_q;
    assign bus.out_data   = s2_data_q;
    assign bus.cfg_err    = cfg_err_q;
    assign bus.eval_count = eval_count_q;

endmodule

// File: tb/tb_lut_bank_pipe.sv
// Directed bench for lut_bank_pipe (K=4, CHANNELS=3, CNT_W=4) with a
// transaction scoreboard checking every delivered beat.
module tb_lut_bank_pipe;
    localparam int             K        = 4;
    localparam int             CHANNELS = 3;
    localparam int             CNT_W    = 4;
    localparam int             TW       = 1 << K;
    localparam logic [TW-1:0]  INIT_TT  = 16'h1796;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    lut_bank_pipe_if #(.K(K), .CHANNELS(CHANNELS), .CNT_W(CNT_W)) bus ();

    lut_bank_pipe #(
        .K(K), .CHANNELS(CHANNELS), .INIT_TT(INIT_TT), .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state, advanced on the falling edge ahead of each rising edge.
    logic [TW-1:0]       tt_m [CHANNELS];
    logic [CNT_W-1:0]    cnt_m;
    logic                err_m;
    logic                held_v;
    logic [CHANNELS-1:0] held_d;
    logic [CHANNELS-1:0] exp_d;
    logic [CHANNELS-1:0] sb [$];

    logic [TW-1:0]       init_v;
    logic [3:0]          t1_x [4];
    logic [2:0]          t1_e [4];
    logic [3:0]          xv;
    int                  n;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CHANNELS-1:0] model_eval(input logic [CHANNELS*K-1:0] d);
        logic [CHANNELS-1:0] r;
        for (int c = 0; c < CHANNELS; c++) r[c] = tt_m[c][d[c*K +: K]];
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            for (int c = 0; c < CHANNELS; c++) tt_m[c] = INIT_TT;
            cnt_m  = '0;
            err_m  = 1'b0;
            held_v = 1'b0;
        end else begin
            check("cfg_err", 32'(bus.cfg_err), 32'(err_m));
            check("eval_count", 32'(bus.eval_count), 32'(cnt_m));
            if (held_v) begin
                check("hold_valid", 32'(bus.out_valid), 32'd1);
                check("hold_data", 32'(bus.out_data), 32'(held_d));
            end
            if (bus.out_valid && bus.out_ready) begin
                check("beat_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    exp_d = sb.pop_front();
                    check("sb_out_data", 32'(bus.out_data), 32'(exp_d));
                end
                if (cnt_m != '1) cnt_m++;
            end
            held_v = bus.out_valid && !bus.out_ready;
            held_d = bus.out_data;
            if (bus.in_valid && bus.in_ready) sb.push_back(model_eval(bus.in_data));
            err_m = bus.cfg_we && (bus.cfg_ch >= CHANNELS);
            if (bus.cfg_we && (bus.cfg_ch < CHANNELS)) tt_m[bus.cfg_ch] = bus.cfg_tt;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [3:0] x2, input logic [3:0] x1, input logic [3:0] x0);
        bus.in_valid = v;
        bus.in_data  = {x2, x1, x0};
    endtask

    // Offers one beat until accepted, optionally toggling out_ready at random.
    task automatic send(input logic [CHANNELS*K-1:0] d, input bit rand_ready);
        int w;
        w = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        forever begin
            if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
            #1;
            if (bus.in_ready || w == 100) break;
            @(posedge clk);
            #1;
            w++;
        end
        check("send_bound", 32'(w < 100), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 200) begin
            step();
            w++;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        init_v = INIT_TT;
        t1_x   = '{4'b0001, 4'b0011, 4'b1000, 4'b1111};
        t1_e   = '{3'b001, 3'b000, 3'b001, 3'b000};

        rst_n         = 1'b0;
        bus.cfg_we    = 1'b0;
        bus.cfg_ch    = '0;
        bus.cfg_tt    = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        repeat (3) step();
        rst_n = 1'b1;

        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_cfg_err", 32'(bus.cfg_err), 32'd0);
        check("rst_eval_count", 32'(bus.eval_count), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Default table streamed on channel 0: two edges from acceptance to output.
        for (int i = 0; i < 6; i++) begin
            if (i < 4) set_in(1'b1, 4'd0, 4'd0, t1_x[i]);
            else       set_in(1'b0, 4'd0, 4'd0, 4'd0);
            step();
            if (i >= 1 && i <= 4) begin
                check("t1_valid", 32'(bus.out_valid), 32'd1);
                check("t1_data", 32'(bus.out_data), 32'(t1_e[i-1]));
            end
            if (i == 5) check("t1_idle", 32'(bus.out_valid), 32'd0);
        end

        // Reprogram channel 1 in the same cycle as an accepted beat.
        bus.cfg_we = 1'b1;
        bus.cfg_ch = 2'd1;
        bus.cfg_tt = 16'h8000;
        set_in(1'b1, 4'd0, 4'b1111, 4'b0001);
        step();
        bus.cfg_we = 1'b0;
        step();
        check("t2_old_table", 32'(bus.out_data), 32'd1);
        set_in(1'b0, 4'd0, 4'd0, 4'd0);
        step();
        check("t2_new_table", 32'(bus.out_data), 32'd3);
        step();
        check("t2_idle", 32'(bus.out_valid), 32'd0);

        // Backpressure: two beats buffer, the third waits for out_ready.
        bus.out_ready = 1'b0;
        set_in(1'b1, 4'd0, 4'd0, 4'b0001);
        #1 check("t3_ready_a", 32'(bus.in_ready), 32'd1);
        step();
        set_in(1'b1, 4'd0, 4'd0, 4'b0000);
        #1 check("t3_ready_b", 32'(bus.in_ready), 32'd1);
        step();
        set_in(1'b1, 4'd0, 4'd0, 4'b0110);
        #1 check("t3_ready_full", 32'(bus.in_ready), 32'd0);
        repeat (2) begin
            step();
            check("t3_stall_valid", 32'(bus.out_valid), 32'd1);
            check("t3_stall_data", 32'(bus.out_data), 32'd1);
            check("t3_stall_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        #1 check("t3_ready_release", 32'(bus.in_ready), 32'd1);
        step();
        set_in(1'b0, 4'd0, 4'd0, 4'd0);
        check("t3_second", 32'(bus.out_data), 32'd0);
        step();
        check("t3_third_valid", 32'(bus.out_valid), 32'd1);
        check("t3_third", 32'(bus.out_data), 32'd0);
        step();
        check("t3_idle", 32'(bus.out_valid), 32'd0);

        // Reset with two beats in flight.
        set_in(1'b1, 4'd0, 4'd0, 4'b0001);
        step();
        set_in(1'b1, 4'd0, 4'd0, 4'b1000);
        step();
        check("t5_inflight", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        set_in(1'b0, 4'd0, 4'd0, 4'd0);
        step();
        rst_n = 1'b1;
        check("t5_valid", 32'(bus.out_valid), 32'd0);
        check("t5_data", 32'(bus.out_data), 32'd0);
        check("t5_count", 32'(bus.eval_count), 32'd0);
        repeat (4) begin
            step();
            check("t5_no_stale", 32'(bus.out_valid), 32'd0);
        end

        // Invalid channel write, then a full sweep proving every table is INIT_TT.
        bus.cfg_we = 1'b1;
        bus.cfg_ch = 2'd3;
        bus.cfg_tt = 16'hFFFF;
        step();
        bus.cfg_we = 1'b0;
        check("t4_err_pulse", 32'(bus.cfg_err), 32'd1);
        step();
        check("t4_err_clear", 32'(bus.cfg_err), 32'd0);
        for (int i = 0; i < 18; i++) begin
            xv = 4'(i);
            if (i < 16) set_in(1'b1, xv, xv, xv);
            else        set_in(1'b0, 4'd0, 4'd0, 4'd0);
            step();
            if (i >= 1 && i <= 16) begin
                xv = 4'(i - 1);
                check("t4_sweep", 32'(bus.out_data), 32'({3{init_v[xv]}}));
            end
        end

        // Counter saturation with random data and random backpressure.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("t6_count_zero", 32'(bus.eval_count), 32'd0);
        for (int i = 0; i < 20; i++) send(12'($urandom), 1'b1);
        bus.out_ready = 1'b1;
        drain();
        step();
        check("t6_saturated", 32'(bus.eval_count), 32'd15);
        n = 0;
        repeat (3) begin
            step();
            n++;
        end
        check("t6_held", 32'(bus.eval_count), 32'd15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
